vx_operands_dispatch: RTL and testbench
=======================================

// Module: vx_operands_dispatch
// PURPOSE
// - Consumer (slave) end of VX_operands_if: takes operand packets from the operand collector.
// - Buffers packets in a 2-entry elastic FIFO and routes each to one execute unit, selected by
//   data.ex_type.
// - Keeps multi-instruction matrix groups (m_instr_cnt>1) atomic and in order on one unit.
// PARAMETERS
// - NUM_EX      `NUM_EX_UNITS  number of execute-unit output lanes; ex_type>=NUM_EX is illegal
// - PERF_W      32             width of each performance counter
// PORTS
// - clk            in     1                  clock
// - reset          in     1                  reset, asynchronous, active-low (0 = reset)
// - operands_if    slave  VX_operands_if     valid/data/ready input
// - dispatch_valid out    NUM_EX             per-unit valid, one-hot or zero
// - dispatch_data  out    $bits(data_t)      FIFO head packet, shared by all lanes
// - dispatch_ready in     NUM_EX             per-unit ready
// - grp_active     out    1                  matrix group lock held
// - grp_err        out    1                  sticky: illegal ex_type seen at head
// - perf_issued    out    NUM_EX*PERF_W      per-unit handshake count
// - perf_stalls    out    PERF_W             cycles where head valid and not accepted
// BEHAVIOUR
// - Reset (reset=0, async):
//   - FIFO count=0, operands_if.ready=0, dispatch_valid=0, dispatch_data=0.
//   - FSM=IDLE, grp_active=0, grp_err=0, counters=0.
//   - ready rises the first cycle after release.
// - Input handshake: packet accepted when valid&&ready.
//   - ready is registered: ready = (count<2) as of the previous edge.
//   - Pop and push in the same cycle are allowed with count 2 -> 2 only if ready was 1.
//   - Data is unchanged when valid=0. Full FIFO holds ready=0, no overwrite.
// - Latency: accepted packet appears at dispatch_data on the next cycle.
//   - Throughput 1 packet/cycle when dispatch_ready is held.
// - Routing: head valid and legal -> dispatch_valid[ex_type]=1.
//   - Pop on dispatch_valid[i]&&dispatch_ready[i].
//   - valid and data must stay stable until the pop (no retraction).
// - Illegal ex_type (>=NUM_EX): head is dropped in 1 cycle, no lane asserted, grp_err set.
//   grp_err clears only on reset.
// - FSM IDLE:
//   - Pop with m_instr_cnt>1 -> GROUP.
//   - Latch gid=m_instr_id, gex=ex_type, rem=m_instr_cnt-1 (4-bit).
//   - m_instr_cnt 0 or 1 is treated as a single packet.
// - FSM GROUP (grp_active=1):
//   - Head is dispatched only if m_instr_id==gid and ex_type==gex.
//   - Otherwise the head stalls and dispatch_valid=0.
//   - Each pop decrements rem. A pop with rem==1 -> IDLE in the same edge, so grp_active=0
//     the next cycle.
// - Simultaneous events:
//   - Group-closing pop and a new group-opening head: the new group is only seen after the
//     head advances (next cycle).
//   - Reset mid-group drops the FIFO contents and lock immediately.
// - Counters wrap modulo 2^PERF_W.
//   - perf_stalls counts head-valid cycles where no pop occurs, including group stalls.
// CONFIGURATION
// - VX_DISPATCH_PERF_EN defined: perf_issued/perf_stalls count as above.
// - Not defined: the counters are not built; both ports are tied to 0 and the ports stay present.
// TESTING
// - Reset: hold reset=0 with operands_if.valid=1 -> ready=0, dispatch_valid=0.
//   Cycle 1 after release -> ready=1.
// - Single packet: ex_type=1, dispatch_ready all 1 -> dispatch_valid=4'b0010 the next cycle,
//   data matches, perf_issued[1]=1.
// - Backpressure: 3 packets back-to-back, dispatch_ready=0 ->
//   - ready drops after the 2nd accept; the 3rd is held on the input.
//   - Release -> all 3 delivered in order, none lost.
// - Group: m_instr_cnt=3, id=5, ex=2, then 3 packets with id=5 ->
//   - grp_active high from the cycle after the 1st pop until the cycle after the 3rd pop.
// - Group stall: inside a group, head has id=6 -> dispatch_valid=0 and perf_stalls increments
//   each cycle. Reset mid-stall -> all state cleared.
// - Illegal: ex_type=NUM_EX -> head dropped in 1 cycle, grp_err=1 sticky, next packet dispatched
//   normally.

Source files
------------

// File: rtl/vx_operands_dispatch.sv
// vx_operands_dispatch: 2-entry elastic buffer routing operand packets to execute lanes, with matrix-group locking; VX_DISPATCH_PERF_EN builds perf counters
module vx_operands_dispatch #(
    parameter int NUM_EX = 4,
    parameter int PERF_W = 32,
    parameter int DATA_W = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     operands_valid,
    input  logic [DATA_W-1:0]        operands_data,
    output logic                     operands_ready,
    output logic [NUM_EX-1:0]        dispatch_valid,
    output logic [DATA_W-1:0]        dispatch_data,
    input  logic [NUM_EX-1:0]        dispatch_ready,
    output logic                     grp_active,
    output logic                     grp_err,
    output logic [NUM_EX*PERF_W-1:0] perf_issued,
    output logic [PERF_W-1:0]        perf_stalls
);
    typedef enum logic {IDLE, GROUP} state_t;
    state_t state, state_n;
    logic [DATA_W-1:0] mem [2];
    logic rd_ptr, wr_ptr;
    logic [1:0] count, count_n;
    logic [3:0] rem, gex, h_ex, h_cnt;
    logic [7:0] gid, h_id;
    logic head_valid, legal, match, push, pop, drop, fire;
    assign head_valid = count != 2'd0;
    assign dispatch_data = head_valid ? mem[rd_ptr] : '0;
    assign h_ex = dispatch_data[3:0];
    assign h_id = dispatch_data[11:4];
    assign h_cnt = dispatch_data[15:12];
    assign legal = 32'(h_ex) < NUM_EX;
    assign match = state == IDLE || (h_id == gid && h_ex == gex);
    assign drop = head_valid && !legal;
    assign fire = |(dispatch_valid & dispatch_ready);
    assign pop = fire || drop;
    assign push = operands_valid && operands_ready;
    assign count_n = count + 2'(push) - 2'(pop);
    // FIFO storage; contents are only visible while count marks them valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= operands_data;
    end
    // FIFO pointers, registered ready and sticky illegal-type flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count <= 2'd0;
            operands_ready <= 1'b0;
            grp_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_n;
            operands_ready <= count_n < 2'd2;
            grp_err <= grp_err || drop;
        end
    end
    // group FSM state register plus the latched group identity and remaining count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rem <= 4'd0;
            gid <= 8'd0;
            gex <= 4'd0;
        end else begin
            state <= state_n;
            if (fire) rem <= (state == IDLE) ? h_cnt - 4'd1 : rem - 4'd1;
            if (fire && state == IDLE) begin
                gid <= h_id;
                gex <= h_ex;
            end
        end
    end
    // a multi-instruction pop opens a group; the pop with one left closes it
    always_comb begin
        state_n = (state == IDLE) ? ((fire && h_cnt > 4'd1) ? GROUP : IDLE)
                                  : ((fire && rem == 4'd1) ? IDLE : GROUP);
    end
    // lane select for a legal head that the group lock (if any) admits
    always_comb begin
        grp_active = state == GROUP;
        dispatch_valid = (head_valid && legal && match) ? NUM_EX'(1) << h_ex : '0;
    end
`ifdef VX_DISPATCH_PERF_EN
    // per-lane handshake counts and head-valid cycles without a pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issued <= '0;
            perf_stalls <= '0;
        end else begin
            for (int i = 0; i < NUM_EX; i++)
                if (dispatch_valid[i] && dispatch_ready[i])
                    perf_issued[i*PERF_W +: PERF_W] <= perf_issued[i*PERF_W +: PERF_W] + PERF_W'(1);
            perf_stalls <= perf_stalls + PERF_W'(head_valid && !pop);
        end
    end
`else
    assign perf_issued = '0;
    assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_vx_operands_dispatch.sv
// tb_vx_operands_dispatch: scoreboard bench for vx_operands_dispatch
module tb_vx_operands_dispatch;
`ifdef VX_DISPATCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic op_valid = 1'b0;
    logic [47:0] op_data = '0;
    logic op_ready;
    logic [3:0] d_valid;
    logic [47:0] d_data;
    logic [3:0] d_ready = 4'hf;
    logic grp_active, grp_err;
    logic [127:0] perf_issued;
    logic [31:0] perf_stalls;
    logic [51:0] q[$];
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] s0;

    vx_operands_dispatch #(.NUM_EX(4), .PERF_W(32), .DATA_W(48)) dut (
        .clk(clk), .reset(reset),
        .operands_valid(op_valid), .operands_data(op_data), .operands_ready(op_ready),
        .dispatch_valid(d_valid), .dispatch_data(d_data), .dispatch_ready(d_ready),
        .grp_active(grp_active), .grp_err(grp_err),
        .perf_issued(perf_issued), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pk(input logic [3:0] ex, input logic [7:0] id,
                                       input logic [3:0] cnt, input logic [31:0] pay);
        return {pay, cnt, id, ex};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [47:0] p, input bit legal);
        bit acc = 1'b0;
        logic [3:0] one;
        op_valid = 1'b1;
        op_data = p;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = op_ready;
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: packet %0h never accepted", p);
        end else if (legal) begin
            one = 4'b0001 << p[3:0];
            q.push_back({one, p});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("sb_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: every handshake must match the oldest expected packet
    always @(negedge clk) begin
        if (reset) begin
            chk("lane_onehot0", 64'($onehot0(d_valid)), 64'd1);
            if (|(d_valid & d_ready)) begin
                if (q.size() == 0) chk("unexpected_dispatch", {12'd0, d_valid, d_data}, 64'd0);
                else begin
                    chk("sb_lane", 64'(d_valid), 64'(q[0][51:48]));
                    chk("sb_data", 64'(d_data), 64'(q[0][47:0]));
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        op_valid = 1'b1;
        op_data = pk(4'd1, 8'd9, 4'd1, 32'hdead);
        cyc(3);
        chk("rst_ready", 64'(op_ready), 64'd0);
        chk("rst_dvalid", 64'(d_valid), 64'd0);
        chk("rst_ddata", 64'(d_data), 64'd0);
        chk("rst_grp", {62'd0, grp_active, grp_err}, 64'd0);
        chk("rst_stalls", 64'(perf_stalls), 64'd0);
        op_valid = 1'b0;
        reset = 1'b1;
        cyc(1);
        chk("ready_after_rst", 64'(op_ready), 64'd1);
        // single packet to lane 1
        send(pk(4'd1, 8'd1, 4'd1, 32'h1111_0001), 1'b1);
        chk("single_dvalid", 64'(d_valid), 64'b0010);
        cyc(1);
        chk("perf_issued1", 64'(perf_issued[63:32]), PERF ? 64'd1 : 64'd0);
        chk("perf_stalls0", 64'(perf_stalls), 64'd0);
        drain();
        // backpressure: three back-to-back, third held at the input
        d_ready = 4'h0;
        send(pk(4'd0, 8'd2, 4'd1, 32'haaaa_0001), 1'b1);
        send(pk(4'd3, 8'd3, 4'd1, 32'haaaa_0002), 1'b1);
        chk("bp_ready_drop", 64'(op_ready), 64'd0);
        fork
            send(pk(4'd2, 8'd4, 4'd1, 32'haaaa_0003), 1'b1);
            begin
                cyc(3);
                chk("bp_ready_held", 64'(op_ready), 64'd0);
                chk("bp_head_lane", 64'(d_valid), 64'b0001);
                d_ready = 4'hf;
            end
        join
        drain();
        // matrix group of three on lane 2
        send(pk(4'd2, 8'd5, 4'd3, 32'hbbbb_0001), 1'b1);
        chk("grp_pre", 64'(grp_active), 64'd0);
        chk("grp_first_lane", 64'(d_valid), 64'b0100);
        send(pk(4'd2, 8'd5, 4'd0, 32'hbbbb_0002), 1'b1);
        chk("grp_open", 64'(grp_active), 64'd1);
        send(pk(4'd2, 8'd5, 4'd0, 32'hbbbb_0003), 1'b1);
        chk("grp_last_pending", 64'(grp_active), 64'd1);
        cyc(1);
        chk("grp_closed", 64'(grp_active), 64'd0);
        drain();
        // group stall on a foreign id, then reset mid-stall
        send(pk(4'd1, 8'd7, 4'd2, 32'hcccc_0001), 1'b1);
        send(pk(4'd1, 8'd6, 4'd1, 32'hcccc_0002), 1'b1);
        chk("stall_grp", 64'(grp_active), 64'd1);
        chk("stall_dvalid", 64'(d_valid), 64'd0);
        s0 = perf_stalls;
        cyc(4);
        chk("stall_dvalid_hold", 64'(d_valid), 64'd0);
        chk("stall_count", 64'(perf_stalls), PERF ? 64'(s0 + 32'd4) : 64'd0);
        reset = 1'b0;
        q.delete();
        #1;
        chk("midrst_grp", 64'(grp_active), 64'd0);
        chk("midrst_dvalid", 64'(d_valid), 64'd0);
        chk("midrst_ready", 64'(op_ready), 64'd0);
        chk("midrst_perf", {perf_stalls, perf_issued[63:32]}, 64'd0);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        chk("ready_after_rst2", 64'(op_ready), 64'd1);
        // illegal ex_type dropped, next packet dispatched normally
        send(pk(4'd4, 8'd0, 4'd1, 32'hdddd_0001), 1'b0);
        chk("ill_no_lane", 64'(d_valid), 64'd0);
        chk("ill_err_pre", 64'(grp_err), 64'd0);
        send(pk(4'd3, 8'd8, 4'd1, 32'hdddd_0002), 1'b1);
        chk("ill_err_set", 64'(grp_err), 64'd1);
        chk("ill_next_lane", 64'(d_valid), 64'b1000);
        cyc(3);
        chk("ill_err_sticky", 64'(grp_err), 64'd1);
        chk("ill_perf_issued3", 64'(perf_issued[127:96]), PERF ? 64'd1 : 64'd0);
        chk("ill_perf_stalls", 64'(perf_stalls), 64'd0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
